// File: rtl/rv_instr_encoder.sv
// rtl/rv_instr_encoder.sv - RV32I field-to-word encoder with S1 register stage and output FIFO
// Optional: RV_INSTR_ENC_NOP_ON_ILLEGAL_EN pushes a NOP in place of each illegal request.
module rv_instr_encoder #(
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [19:0]      req_imm,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] FMT_U = 2'd0, FMT_I = 2'd1, FMT_SH = 2'd2, FMT_R = 2'd3;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        s1_valid;
    logic [4:0]  s1_op, s1_rd, s1_rs1, s1_rs2;
    logic [19:0] s1_imm;

    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [31:0]   mem [DEPTH];

    logic [1:0]  fmt;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic        enc_legal;
    logic [31:0] enc_word, push_word;
    logic        push, pop, accept, err_ev;
    logic [AW+1:0] occ;

    // S1 counts as occupied so an accepted request always finds a FIFO slot one edge later.
    assign occ       = {1'b0, count} + {{(AW+1){1'b0}}, s1_valid};
    assign req_ready = !flush && (occ < (AW+2)'(DEPTH));
    assign accept    = req_valid && req_ready;

    always_comb begin
        fmt       = FMT_R;
        opcode    = 7'b0110011;
        f3        = 3'b000;
        f7        = 7'b0000000;
        enc_legal = 1'b1;
        case (s1_op)
            5'd0:  begin fmt = FMT_U; opcode = 7'b0110111; end
            5'd1:  begin fmt = FMT_U; opcode = 7'b0010111; end
            5'd2:  begin fmt = FMT_I; opcode = 7'b0010011; f3 = 3'b000; end
            5'd3:  begin fmt = FMT_I; opcode = 7'b0010011; f3 = 3'b010; end
            5'd4:  begin fmt = FMT_I; opcode = 7'b0010011; f3 = 3'b011; end
            5'd5:  begin fmt = FMT_I; opcode = 7'b0010011; f3 = 3'b100; end
            5'd6:  begin fmt = FMT_I; opcode = 7'b0010011; f3 = 3'b110; end
            5'd7:  begin fmt = FMT_I; opcode = 7'b0010011; f3 = 3'b111; end
            5'd8:  begin fmt = FMT_SH; opcode = 7'b0010011; f3 = 3'b001; end
            5'd9:  begin fmt = FMT_SH; opcode = 7'b0010011; f3 = 3'b101; end
            5'd10: begin fmt = FMT_SH; opcode = 7'b0010011; f3 = 3'b101; f7 = 7'b0100000; end
            5'd11: f3 = 3'b000;
            5'd12: begin f3 = 3'b000; f7 = 7'b0100000; end
            5'd13: f3 = 3'b001;
            5'd14: f3 = 3'b010;
            5'd15: f3 = 3'b011;
            5'd16: f3 = 3'b100;
            5'd17: f3 = 3'b101;
            5'd18: begin f3 = 3'b101; f7 = 7'b0100000; end
            5'd19: f3 = 3'b110;
            5'd20: f3 = 3'b111;
            default: enc_legal = 1'b0;
        endcase
        if (fmt == FMT_SH && s1_imm[11:5] != 7'd0)
            enc_legal = 1'b0;
        case (fmt)
            FMT_U:   enc_word = {s1_imm, s1_rd, opcode};
            FMT_I:   enc_word = {s1_imm[11:0], s1_rs1, f3, s1_rd, opcode};
            FMT_SH:  enc_word = {f7, s1_imm[4:0], s1_rs1, f3, s1_rd, opcode};
            default: enc_word = {f7, s1_rs2, s1_rs1, f3, s1_rd, opcode};
        endcase
    end

    assign err_ev = s1_valid && !enc_legal && !flush;
`ifdef RV_INSTR_ENC_NOP_ON_ILLEGAL_EN
    assign push      = s1_valid && !flush;
    assign push_word = enc_legal ? enc_word : NOP_WORD;
`else
    assign push      = s1_valid && !flush && enc_legal;
    assign push_word = enc_word;
`endif
    assign pop         = instr_valid && instr_ready && !flush;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? mem[rptr] : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_rd    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_imm   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op  <= req_op;
                s1_rd  <= req_rd;
                s1_rs1 <= req_rs1;
                s1_rs2 <= req_rs2;
                s1_imm <= req_imm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= err_ev;
            if (err_ev && err_cnt != {ERR_W{1'b1}})
                err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule
